// File: rtl/stack_pc.sv
// Control unit for the stack datapath: accepts stack ops over valid/ready and
// emits one Moore alpha/beta control word per cycle, tracking depth in a shadow counter.
module stack_pc #(
    parameter int         DEPTH   = 1024,
    parameter int         CNT_W   = 11,
    parameter logic [2:0] ALU_ADD = 3'd0,
    parameter logic [2:0] ALU_SUB = 3'd1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       op,
    input  logic             op_valid,
    output logic             op_ready,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] count,
    output logic             alpha_k1,
    output logic             alpha_k2,
    output logic             alpha_k3,
    output logic             alpha_k4,
    output logic             alpha_k5,
    output logic             alpha_k_ind,
    output logic             alpha_k_i,
    output logic             alpha_k_esito,
    output logic             alpha_k_dataout,
    output logic             alpha_k_mem1,
    output logic             alpha_k_mem2,
    output logic [2:0]       alpha_alu2,
    output logic [2:0]       alpha_alu3,
    output logic [2:0]       alpha_alu4,
    output logic             beta_hd,
    output logic             beta_ind,
    output logic             beta_i,
    output logic             beta_esito,
    output logic             beta_datain,
    output logic             beta_dataout,
    output logic             beta_mem
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PUSH_WR, S_RD, S_BIN1, S_BIN2, S_ERR
    } state_t;

    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_POP  = 3'd1;
    localparam logic [2:0] OP_TOP  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

    state_t           state_reg, state_next;
    logic [2:0]       op_reg, op_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;

    // The datapath hd register must share this reset so hd and count stay aligned.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            op_reg    <= OP_PUSH;
            count_reg <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            count_reg <= count_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        count_next = count_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (op_valid) begin
                    op_next = op;
                    case (op)
                        OP_PUSH:        state_next = (count_reg == CNT_FULL) ? S_ERR : S_LOAD;
                        OP_POP, OP_TOP: state_next = (count_reg == '0)       ? S_ERR : S_RD;
                        OP_ADD, OP_SUB: state_next = (count_reg < CNT_TWO)   ? S_ERR : S_BIN1;
                        default:        state_next = S_ERR;
                    endcase
                end
            end
            S_LOAD:    state_next = S_PUSH_WR;
            S_PUSH_WR: begin
                count_next = count_reg + CNT_ONE;
                state_next = S_IDLE;
                done_next  = 1'b1;
            end
            S_RD: begin
                if (op_reg == OP_POP) count_next = count_reg - CNT_ONE;
                state_next = S_IDLE;
                done_next  = 1'b1;
            end
            S_BIN1: begin
                count_next = count_reg - CNT_ONE;
                state_next = S_BIN2;
            end
            S_BIN2: begin
                count_next = count_reg - CNT_ONE;
                state_next = S_IDLE;
                done_next  = 1'b1;
            end
            S_ERR: begin
                state_next = S_IDLE;
                done_next  = 1'b1;
                err_next   = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Control word decode; RD and BIN1 also look at the op latched at accept.
    always_comb begin
        alpha_k1        = 1'b0;
        alpha_k2        = 1'b0;
        alpha_k3        = 1'b0;
        alpha_k4        = 1'b0;
        alpha_k5        = 1'b0;
        alpha_k_ind     = 1'b0;
        alpha_k_i       = 1'b0;
        alpha_k_esito   = 1'b0;
        alpha_k_dataout = 1'b0;
        alpha_k_mem1    = 1'b0;
        alpha_k_mem2    = 1'b0;
        alpha_alu2      = ALU_ADD;
        alpha_alu3      = ALU_ADD;
        alpha_alu4      = ALU_ADD;
        beta_hd         = 1'b0;
        beta_ind        = 1'b0;
        beta_i          = 1'b0;
        beta_esito      = 1'b0;
        beta_datain     = 1'b0;
        beta_dataout    = 1'b0;
        beta_mem        = 1'b0;
        case (state_reg)
            S_LOAD: beta_datain = 1'b1;
            S_PUSH_WR: begin
                beta_mem   = 1'b1;
                alpha_alu3 = ALU_ADD;
                beta_hd    = 1'b1;
            end
            S_RD: begin
                alpha_alu3   = ALU_SUB;
                alpha_k_mem1 = 1'b1;
                beta_dataout = 1'b1;
                beta_hd      = (op_reg == OP_POP);
            end
            S_BIN1: begin
                alpha_alu3      = ALU_SUB;
                alpha_k_mem1    = 1'b1;
                alpha_k5        = 1'b1;
                alpha_alu4      = ALU_SUB;
                alpha_alu2      = (op_reg == OP_SUB) ? ALU_SUB : ALU_ADD;
                alpha_k_dataout = 1'b1;
                beta_dataout    = 1'b1;
                beta_hd         = 1'b1;
            end
            S_BIN2: begin
                alpha_alu3 = ALU_SUB;
                beta_hd    = 1'b1;
            end
            default: ;
        endcase
    end

    assign op_ready = (state_reg == S_IDLE);
    assign done     = done_reg;
    assign err      = err_reg;
    assign count    = count_reg;

endmodule

// File: tb/tb_stack_pc.sv
// Bench for stack_pc: directed and random ops checked against a depth-only stack
// model that predicts per-cycle control words, latency, completion and count.
module tb_stack_pc;
    localparam int         DEPTH   = 1024;
    localparam int         CNT_W   = 11;
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [2:0] op = 3'd0;
    logic op_valid = 1'b0;
    logic op_ready, done, err;
    logic [CNT_W-1:0] count;
    logic alpha_k1, alpha_k2, alpha_k3, alpha_k4, alpha_k5;
    logic alpha_k_ind, alpha_k_i, alpha_k_esito, alpha_k_dataout, alpha_k_mem1, alpha_k_mem2;
    logic [2:0] alpha_alu2, alpha_alu3, alpha_alu4;
    logic beta_hd, beta_ind, beta_i, beta_esito, beta_datain, beta_dataout, beta_mem;
    logic [26:0] word;

    int total = 0;
    int bad = 0;
    int depth = 0;

    stack_pc #(.DEPTH(DEPTH), .CNT_W(CNT_W), .ALU_ADD(ALU_ADD), .ALU_SUB(ALU_SUB)) dut (
        .clock(clock), .reset(reset), .op(op), .op_valid(op_valid),
        .op_ready(op_ready), .done(done), .err(err), .count(count),
        .alpha_k1(alpha_k1), .alpha_k2(alpha_k2), .alpha_k3(alpha_k3),
        .alpha_k4(alpha_k4), .alpha_k5(alpha_k5), .alpha_k_ind(alpha_k_ind),
        .alpha_k_i(alpha_k_i), .alpha_k_esito(alpha_k_esito),
        .alpha_k_dataout(alpha_k_dataout), .alpha_k_mem1(alpha_k_mem1),
        .alpha_k_mem2(alpha_k_mem2), .alpha_alu2(alpha_alu2),
        .alpha_alu3(alpha_alu3), .alpha_alu4(alpha_alu4),
        .beta_hd(beta_hd), .beta_ind(beta_ind), .beta_i(beta_i),
        .beta_esito(beta_esito), .beta_datain(beta_datain),
        .beta_dataout(beta_dataout), .beta_mem(beta_mem)
    );

    always #5 clock = ~clock;

    assign word = {alpha_k1, alpha_k2, alpha_k3, alpha_k4, alpha_k5, alpha_k_ind, alpha_k_i,
                   alpha_k_esito, alpha_k_dataout, alpha_k_mem1, alpha_k_mem2,
                   alpha_alu2, alpha_alu3, alpha_alu4,
                   beta_hd, beta_ind, beta_i, beta_esito, beta_datain, beta_dataout, beta_mem};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected control word for cycle 'step' (1-based) after accepting op o.
    function automatic logic [26:0] exp_word(input logic [2:0] o, input int step, input bit rej);
        logic k5, kd, km1, bhd, bdi, bdo, bm;
        logic [2:0] a2, a3, a4;
        k5 = 0; kd = 0; km1 = 0; bhd = 0; bdi = 0; bdo = 0; bm = 0;
        a2 = ALU_ADD; a3 = ALU_ADD; a4 = ALU_ADD;
        if (!rej) begin
            case (o)
                3'd0: if (step == 1) bdi = 1; else begin bm = 1; bhd = 1; a3 = ALU_ADD; end
                3'd1, 3'd2: begin km1 = 1; a3 = ALU_SUB; bdo = 1; bhd = (o == 3'd1); end
                3'd3, 3'd4: begin
                    if (step == 1) begin
                        km1 = 1; a3 = ALU_SUB; k5 = 1; a4 = ALU_SUB;
                        a2 = (o == 3'd3) ? ALU_ADD : ALU_SUB;
                        kd = 1; bdo = 1; bhd = 1;
                    end else begin
                        a3 = ALU_SUB; bhd = 1;
                    end
                end
                default: ;
            endcase
        end
        return {4'b0000, k5, 3'b000, kd, km1, 1'b0, a2, a3, a4, bhd, 3'b000, bdi, bdo, bm};
    endfunction

    // Presents o in the current (IDLE) cycle and follows it to its done cycle.
    task automatic run_op(input logic [2:0] o, input bit hold);
        bit rej;
        int lat, d;
        case (o)
            3'd0:    begin rej = (depth == DEPTH); lat = 3; d = 1;  end
            3'd1:    begin rej = (depth == 0);     lat = 2; d = -1; end
            3'd2:    begin rej = (depth == 0);     lat = 2; d = 0;  end
            3'd3,
            3'd4:    begin rej = (depth < 2);      lat = 3; d = -2; end
            default: begin rej = 1;                lat = 2; d = 0;  end
        endcase
        if (rej) begin lat = 2; d = 0; end
        op = o;
        op_valid = 1'b1;
        chk("accept_ready", 32'(op_ready), 32'd1);
        tick();
        if (!hold) op_valid = 1'b0;
        for (int s = 1; s < lat; s++) begin
            chk($sformatf("word op%0d s%0d", o, s), 32'(word), 32'(exp_word(o, s, rej)));
            chk("busy_done", 32'(done), 32'd0);
            chk("busy_ready", 32'(op_ready), 32'd0);
            tick();
        end
        depth += d;
        chk($sformatf("done op%0d", o), 32'(done), 32'd1);
        chk($sformatf("err op%0d", o), 32'(err), 32'(rej));
        chk("count", 32'(count), 32'(depth));
        chk("done_ready", 32'(op_ready), 32'd1);
        chk("idle_word", 32'(word), 32'd0);
    endtask

    task automatic idle_tick();
        op_valid = 1'b0;
        tick();
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_ready", 32'(op_ready), 32'd1);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        op_valid = 1'b0;
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_word", 32'(word), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        tick();
        reset = 1'b0;
        depth = 0;
        tick();
        chk("rel_ready", 32'(op_ready), 32'd1);
        chk("rel_done", 32'(done), 32'd0);
    endtask

    initial begin
        int r;
        logic [2:0] o;
        // power-on reset
        apply_reset();

        // reset in the middle of an ADD (in BIN1)
        run_op(3'd0, 0);
        run_op(3'd0, 0);
        op = 3'd3;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        chk("bin1_word", 32'(word), 32'(exp_word(3'd3, 1, 0)));
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_word", 32'(word), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        #3 reset = 1'b0;
        depth = 0;
        tick();
        chk("mid_rel_done", 32'(done), 32'd0);
        chk("mid_rel_ready", 32'(op_ready), 32'd1);
        chk("mid_rel_count", 32'(count), 32'd0);
        idle_tick();

        // directed: PUSH, PUSH, TOP, ADD; PUSH, PUSH, SUB; rejections
        run_op(3'd0, 0);
        run_op(3'd0, 0);
        run_op(3'd2, 0);
        run_op(3'd3, 0);
        idle_tick();
        run_op(3'd0, 0);
        run_op(3'd0, 0);
        run_op(3'd4, 0);
        run_op(3'd1, 0);
        run_op(3'd7, 0);
        run_op(3'd5, 0);
        run_op(3'd3, 0);
        run_op(3'd0, 0);
        run_op(3'd4, 0);
        run_op(3'd1, 0);
        idle_tick();

        // overflow
        for (int i = 0; i < DEPTH; i++) run_op(3'd0, 1);
        run_op(3'd0, 1);
        chk("full_count", 32'(count), 32'(DEPTH));
        run_op(3'd2, 0);
        run_op(3'd3, 0);
        apply_reset();

        // back-to-back with op_valid held high throughout
        run_op(3'd0, 1);
        run_op(3'd1, 1);
        run_op(3'd0, 1);
        chk("b2b_count", 32'(count), 32'd1);
        idle_tick();

        // random
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 3)      o = 3'd0;
            else if (r == 4) o = 3'd1;
            else if (r == 5) o = 3'd2;
            else if (r == 6) o = 3'd3;
            else if (r == 7) o = 3'd4;
            else             o = 3'($urandom_range(5, 7));
            run_op(o, bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_tick();
        end
        op_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stack_pc.md
Name: stack_pc

Overview:
- Control part (parte controllo) for the stack-unit datapath.
- Accepts stack operations from a requester over a valid/ready handshake.
- Sequences the datapath's alpha (mux/ALU select) and beta (register/memory write-enable) control inputs, one control word per cycle.
- Keeps a shadow depth counter so overflow/underflow are caught without datapath condition outputs.

Parameters:
DEPTH, 1024, stack capacity in words; must equal datapath memory size
CNT_W, 11, width of depth counter and count output
ALU_ADD, 3'd0, datapath ALU function code for A+B
ALU_SUB, 3'd1, datapath ALU function code for A-B

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears FSM and counter
op  input  3  000 PUSH, 001 POP, 010 TOP, 011 ADD, 100 SUB, others illegal
op_valid  input  1  request present; op held stable until accepted
op_ready  output  1  high only in IDLE; accept = op_valid & op_ready at rising edge
done  output  1  one-cycle pulse on operation completion
err  output  1  qualified by done; 1 = op rejected, datapath untouched
count  output  CNT_W  current stack depth
alpha_k1, alpha_k2, alpha_k3, alpha_k4, alpha_k5  output  1 each  mux selects
alpha_k_ind, alpha_k_i, alpha_k_esito, alpha_k_dataout, alpha_k_mem1, alpha_k_mem2  output  1 each  mux selects
alpha_alu2, alpha_alu3, alpha_alu4  output  3 each  ALU function codes
beta_hd, beta_ind, beta_i, beta_esito, beta_datain, beta_dataout, beta_mem  output  1 each  write enables

Behaviour:
- Mux convention: alpha=0 selects the first data input, alpha=1 the second.
- Memory addressing: read port 1 and write port use the k_mem1 address; read port 2 uses the k_mem2 address.
- Reset:
  - State goes to IDLE and count to 0.
  - All alpha and beta outputs go to 0, and done and err go to 0.
  - op_ready goes to 1 after reset deasserts.
  - Reset mid-operation aborts the operation with no done pulse. The system must reset the datapath hd register alongside.
- Default control word in every state: all alpha = 0, all beta = 0 (Moore outputs, decoded from state only). The fields listed below are the only non-default ones.
- States: IDLE, LOAD, PUSH_WR, RD, BIN1, BIN2, ERR.
- IDLE transitions on accept:
  - illegal op -> ERR
  - PUSH with count==DEPTH -> ERR
  - POP/TOP with count==0 -> ERR
  - ADD/SUB with count<2 -> ERR
  - otherwise PUSH -> LOAD, POP/TOP -> RD, ADD/SUB -> BIN1
- The op is latched at accept. The requester must hold datain_val stable from accept through the LOAD cycle.
- LOAD: beta_datain=1. Next state PUSH_WR.
- PUSH_WR: alpha_k_mem1=0 (hd), beta_mem=1; alpha_k3=0, alpha_alu3=ALU_ADD, beta_hd=1. count+1. Next state IDLE.
- RD (address hd-1):
  - alpha_k3=0, alpha_alu3=ALU_SUB, alpha_k_mem1=1, alpha_k_dataout=0, beta_dataout=1.
  - POP only: beta_hd=1 and count-1. TOP leaves hd and count unchanged.
  - Next state IDLE.
- BIN1:
  - Port 1 address hd-1 as in RD. Port 2 address hd-2: alpha_k4=0, alpha_k5=1, alpha_alu4=ALU_SUB, alpha_k_mem2=0.
  - alpha_k1=0, alpha_k2=0, alpha_alu2 = ALU_ADD (ADD) or ALU_SUB (SUB), giving mem[hd-1] op mem[hd-2].
  - alpha_k_dataout=1, beta_dataout=1, beta_hd=1. count-1. Next state BIN2.
- BIN2: alpha_k3=0, alpha_alu3=ALU_SUB, beta_hd=1. count-1. Next state IDLE.
- ERR: control word stays at default. Next state IDLE.
- Completion:
  - done=1 in the first IDLE cycle after the last state; err=1 in that cycle iff the path went through ERR.
  - op_ready is also 1 in that cycle, so back-to-back accept is allowed.
- Latency (accept edge to done cycle): PUSH 3, POP/TOP 2, ADD/SUB 3, rejected 2.
- op_valid while not in IDLE is ignored (op_ready=0).
- count never wraps: a full stack rejects PUSH, an empty stack rejects POP/TOP/ADD/SUB.

Test Plan:
- Reset mid-operation: assert reset during BIN1 -> state IDLE, count=0, all beta=0, no done pulse; after release op_ready=1.
- PUSH 5 then PUSH 7 -> each: beta_datain in cycle 1, beta_mem+beta_hd in cycle 2, done at +3, count=1 then 2; TOP -> dataout=7, count stays 2, done at +2.
- ADD on stack [5,7] -> BIN1 drives alpha_alu2=ALU_ADD, alpha_alu4=ALU_SUB, alpha_k5=1; dataout=12, count=0, done at +3, err=0.
- PUSH 3, PUSH 10, SUB -> dataout=7 (10-3), count=0.
- Underflow and illegal: POP at count=0 -> done with err=1, no beta asserted; op=111 -> same. Overflow: 1024 PUSHes then a 1025th -> err=1, count stays 1024.
- Back-to-back: op_valid held high with PUSH, POP, PUSH -> each accepted in the done cycle of the previous op, no cycle lost; final count=1.
